// File: rtl/rot_cmd_sequencer.sv
// Command-driven sequencer for a WIDTH-bit rotate/shift register.
// Accepts LOAD/ROTL/ROTR/ASR over valid/ready and runs shifts one step per clock.
module rot_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             step,
    output logic [AMT_W-1:0] remaining,
    output logic             done
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_ROTL = 2'd1,
        OP_ROTR = 2'd2,
        OP_ASR  = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [AMT_W-1:0] AMT_ZERO = '0;
    localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic             r_step;
    logic [AMT_W-1:0] r_remaining;
    logic             r_done;

    state_e           w_state_nxt;
    op_e              w_op_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_busy_nxt;
    logic             w_step_nxt;
    logic [AMT_W-1:0] w_remaining_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    op_e              w_cmd_op;

    // One shift step of the register; LOAD never reaches here while running.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] val,
                                                    input op_e op);
        logic [WIDTH-1:0] res;
        res = val;
        case (op)
            OP_ROTL: res = {val[WIDTH-2:0], val[WIDTH-1]};
            OP_ROTR: res = {val[0], val[WIDTH-1:1]};
            OP_ASR:  res = {val[WIDTH-1], val[WIDTH-1:1]};
            default: res = val;
        endcase
        return res;
    endfunction

    assign cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cmd_op  = op_e'(cmd_op);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_q_nxt         = r_q;
        w_busy_nxt      = r_busy;
        w_step_nxt      = 1'b0;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_op == OP_LOAD) begin
                        w_q_nxt    = cmd_data;
                        w_done_nxt = 1'b1;
                    end else if (cmd_amount == AMT_ZERO) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_op_nxt        = w_cmd_op;
                        w_remaining_nxt = cmd_amount;
                        w_busy_nxt      = 1'b1;
                        w_state_nxt     = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!hold) begin
                    w_q_nxt         = shift_once(r_q, r_op);
                    w_remaining_nxt = r_remaining - AMT_ONE;
                    w_step_nxt      = 1'b1;
                    if (r_remaining == AMT_ONE) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LOAD;
            r_q         <= '0;
            r_busy      <= 1'b0;
            r_step      <= 1'b0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_q         <= w_q_nxt;
            r_busy      <= w_busy_nxt;
            r_step      <= w_step_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign q         = r_q;
    assign busy      = r_busy;
    assign step      = r_step;
    assign remaining = r_remaining;
    assign done      = r_done;

endmodule
